// File: rtl/thermostat_ctrl.sv
// Single-zone heat/cool controller: runtime setpoint, hysteresis band,
// anti-short-cycle dwell lockout and a saturating actuation counter.
module thermostat_ctrl #(
    parameter int TEMP_W = 5,
    parameter int HYST   = 2,
    parameter int DWELL  = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temperature,
    input  logic [TEMP_W-1:0] setpoint,
    output logic              heating,
    output logic              cooling,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  switch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HEAT = 2'b10,
        COOL = 2'b01
    } state_e;

    localparam int              DW_W      = (DWELL < 1) ? 1 : $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(DWELL);
    localparam logic [TEMP_W:0] HYST_X    = (TEMP_W + 1)'(HYST);
    localparam logic [TEMP_W:0] T_MAX     = {1'b0, {TEMP_W{1'b1}}};
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e            state_q, state_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [TEMP_W:0]   temp_x, sp_x, lo, hi, hi_sum;
    logic [DW_W-1:0]   dwell_inc;
    logic              dwell_ok;

    always_comb begin
        temp_x = {1'b0, temperature};
        sp_x   = {1'b0, setpoint};
        lo     = (sp_x < HYST_X) ? '0 : sp_x - HYST_X;
        hi_sum = sp_x + HYST_X;
        hi     = (hi_sum > T_MAX) ? T_MAX : hi_sum;
    end

    // The dwell check counts the current cycle, so a state entered at edge N
    // may be left at edge N+DWELL at the earliest.
    always_comb begin
        dwell_inc = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DW_W'(1);
        dwell_ok  = (DWELL == 0) || (dwell_inc == DWELL_MAX);
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        dwell_d = dwell_inc;
        cnt_d   = cnt_q;

        if (!enable) begin
            state_d = IDLE;
        end else if (temp_valid && dwell_ok) begin
            unique case (state_q)
                IDLE: begin
                    if (temp_x <= lo)      state_d = HEAT;
                    else if (temp_x >= hi) state_d = COOL;
                end
                HEAT:    if (temp_x >= sp_x) state_d = IDLE;
                COOL:    if (temp_x <= sp_x) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q) begin
            dwell_d = '0;
            if (state_d != IDLE && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= IDLE;
            dwell_q <= DWELL_MAX;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state      = state_q;
    assign heating    = state_q[1];
    assign cooling    = state_q[0];
    assign switch_cnt = cnt_q;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Bench for thermostat_ctrl: four parameterisations share control inputs and
// are checked every edge against a cycle-age reference model.
module tb_thermostat_ctrl;

    localparam int NDUT = 4;
    // dut0: defaults, dut1: DWELL=0, dut2: TEMP_W=2/HYST=3/DWELL=0, dut3: CNT_W=2/DWELL=0
    int p_w [NDUT] = '{5, 5, 2, 5};
    int p_h [NDUT] = '{2, 2, 3, 2};
    int p_d [NDUT] = '{4, 0, 0, 0};
    int p_c [NDUT] = '{8, 8, 8, 2};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       temp_valid = 1'b0;
    logic [4:0] temp5 = '0;
    logic [4:0] sp5 = '0;
    logic [1:0] temp2 = '0;
    logic [1:0] sp2v = '0;

    logic [1:0] d_state [NDUT];
    logic       d_heat  [NDUT];
    logic       d_cool  [NDUT];
    logic [7:0] d_cnt   [NDUT];
    logic [1:0] cnt_c2;

    int m_st  [NDUT];
    int m_age [NDUT];
    int m_cnt [NDUT];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    thermostat_ctrl u_d4 (
        .clk(clk), .rst(rst), .enable(enable), .temp_valid(temp_valid),
        .temperature(temp5), .setpoint(sp5), .heating(d_heat[0]),
        .cooling(d_cool[0]), .state(d_state[0]), .switch_cnt(d_cnt[0])
    );

    thermostat_ctrl #(.DWELL(0)) u_d0 (
        .clk(clk), .rst(rst), .enable(enable), .temp_valid(temp_valid),
        .temperature(temp5), .setpoint(sp5), .heating(d_heat[1]),
        .cooling(d_cool[1]), .state(d_state[1]), .switch_cnt(d_cnt[1])
    );

    thermostat_ctrl #(.TEMP_W(2), .HYST(3), .DWELL(0)) u_w2 (
        .clk(clk), .rst(rst), .enable(enable), .temp_valid(temp_valid),
        .temperature(temp2), .setpoint(sp2v), .heating(d_heat[2]),
        .cooling(d_cool[2]), .state(d_state[2]), .switch_cnt(d_cnt[2])
    );

    thermostat_ctrl #(.CNT_W(2), .DWELL(0)) u_c2 (
        .clk(clk), .rst(rst), .enable(enable), .temp_valid(temp_valid),
        .temperature(temp5), .setpoint(sp5), .heating(d_heat[3]),
        .cooling(d_cool[3]), .state(d_state[3]), .switch_cnt(cnt_c2)
    );

    assign d_cnt[3] = {6'b0, cnt_c2};

    task automatic check(input string tag, input int idx, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d: got %0h expected %0h", tag, idx, obs, exp);
        end
    endtask

    // Model: state 0=idle 1=heat 2=cool; age = edges since entering the state.
    task automatic model_edge(input int i, input bit r, input bit e, input bit v,
                              input int t, input int sp);
        int lo, hi, tmax, nxt;
        if (r) begin
            m_st[i]  = 0;
            m_cnt[i] = 0;
            m_age[i] = 1 << 20;
            return;
        end
        tmax = (1 << p_w[i]) - 1;
        lo   = (sp - p_h[i] < 0) ? 0 : sp - p_h[i];
        hi   = (sp + p_h[i] > tmax) ? tmax : sp + p_h[i];
        nxt  = m_st[i];
        if (!e) nxt = 0;
        else if (v && (p_d[i] == 0 || m_age[i] + 1 >= p_d[i])) begin
            if (m_st[i] == 0) begin
                if (t <= lo)      nxt = 1;
                else if (t >= hi) nxt = 2;
            end else if (m_st[i] == 1) begin
                if (t >= sp) nxt = 0;
            end else begin
                if (t <= sp) nxt = 0;
            end
        end
        if (nxt != m_st[i]) begin
            m_age[i] = 0;
            if (nxt != 0 && m_cnt[i] < (1 << p_c[i]) - 1) m_cnt[i]++;
        end else if (m_age[i] < (1 << 20)) begin
            m_age[i]++;
        end
        m_st[i] = nxt;
    endtask

    function automatic logic [1:0] enc(input int s);
        return (s == 1) ? 2'b10 : (s == 2) ? 2'b01 : 2'b00;
    endfunction

    task automatic step(input bit r, input bit e, input bit v, input int t,
                        input int sp, input int t2, input int sp2);
        rst        = r;
        enable     = e;
        temp_valid = v;
        temp5      = t[4:0];
        sp5        = sp[4:0];
        temp2      = t2[1:0];
        sp2v       = sp2[1:0];
        @(posedge clk);
        #1;
        for (int i = 0; i < NDUT; i++) begin
            model_edge(i, r, e, v, (i == 2) ? t2 : t, (i == 2) ? sp2 : sp);
            check("state",   i, {30'b0, d_state[i]}, {30'b0, enc(m_st[i])});
            check("heating", i, {31'b0, d_heat[i]},  {31'b0, m_st[i] == 1});
            check("cooling", i, {31'b0, d_cool[i]},  {31'b0, m_st[i] == 2});
            check("swcnt",   i, {24'b0, d_cnt[i]},   m_cnt[i]);
        end
    endtask

    int band_t   [8] = '{19, 18, 19, 20, 21, 22, 21, 20};
    int band_exp [8] = '{0, 2, 2, 0, 0, 1, 1, 0};
    int dwell_exp[8] = '{2, 2, 2, 0, 0, 0, 0, 1};

    initial begin
        // Reset held with an actionable sample present
        step(1, 1, 1, 25, 20, 3, 1);
        check("rst_state", 0, {30'b0, d_state[0]}, 0);
        step(1, 1, 1, 25, 20, 3, 1);
        check("rst_cnt", 0, {24'b0, d_cnt[0]}, 0);
        step(0, 1, 1, 25, 20, 3, 1);
        check("rel_cool", 0, {30'b0, d_state[0]}, 1);
        check("rel_cnt", 0, {24'b0, d_cnt[0]}, 1);

        // Band walk on the DWELL=0 instance
        step(1, 1, 0, 0, 20, 0, 1);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 1, band_t[k], 20, 1, 1);
            check("band", 1, {30'b0, d_state[1]}, band_exp[k]);
        end
        check("band_cnt", 1, {24'b0, d_cnt[1]}, 2);

        // Dwell lockout: HEAT at edge 0, IDLE at edge 4, COOL at edge 8
        step(1, 1, 0, 0, 20, 0, 1);
        step(0, 1, 1, 17, 20, 0, 1);
        check("dwell_e0", 0, {30'b0, d_state[0]}, 2);
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 1, 25, 20, 3, 1);
            check("dwell", 0, {30'b0, d_state[0]}, dwell_exp[k]);
        end

        // Hold on temp_valid=0, then enable drop overrides dwell
        step(1, 1, 0, 0, 20, 0, 1);
        step(0, 1, 1, 17, 20, 0, 1);
        step(0, 1, 0, 31, 20, 3, 1);
        check("hold", 0, {30'b0, d_state[0]}, 2);
        step(0, 0, 0, 31, 20, 3, 1);
        check("en_drop", 0, {30'b0, d_state[0]}, 0);
        step(0, 0, 1, 0, 20, 0, 1);
        step(0, 0, 1, 0, 20, 0, 1);
        check("en_off", 0, {30'b0, d_state[0]}, 0);

        // Clamping at both rails
        step(1, 1, 0, 0, 1, 0, 1);
        step(0, 1, 1, 0, 1, 0, 1);
        check("clamp_lo", 0, {30'b0, d_state[0]}, 2);
        check("clamp_lo_w2", 2, {30'b0, d_state[2]}, 2);
        step(1, 1, 0, 0, 30, 0, 1);
        step(0, 1, 1, 31, 30, 3, 1);
        check("clamp_hi", 0, {30'b0, d_state[0]}, 1);
        check("clamp_hi_w2", 2, {30'b0, d_state[2]}, 1);

        // Counter saturation on the CNT_W=2 instance
        step(1, 1, 0, 0, 20, 0, 1);
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 1, 17, 20, 0, 1);
            step(0, 1, 1, 20, 20, 1, 1);
        end
        check("sat", 3, {24'b0, d_cnt[3]}, 3);
        check("nosat", 1, {24'b0, d_cnt[1]}, 10);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            int sp;
            sp = $urandom_range(0, 31);
            step($urandom_range(0, 49) == 0, $urandom_range(0, 15) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 31), sp,
                 $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
